// File: rtl/fpu_pkg.sv
// Shared definitions for the FP add/sub/compare unit and the logic around it:
// operation codes, reference constants and the op-to-mode decode.
package fpu_pkg;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_SUB = 2'b01,
        FP_CMP = 2'b10
    } fp_op_e;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP_PINF = 32'h7F800000;
    localparam logic [31:0] FP_NINF = 32'hFF800000;

    // Mode bits presented to the unit.
    typedef struct packed {
        logic sub;
        logic comp;
    } fu_mode_t;

    // Reserved code 2'b11 falls into the default arm and behaves as an add.
    function automatic fu_mode_t decode_op(input logic [1:0] op);
        fu_mode_t m;
        m = '0;
        case (fp_op_e'(op))
            FP_SUB:  m.sub  = 1'b1;
            FP_CMP:  m.comp = 1'b1;
            default: m      = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fpu_addsub_arbiter_rr.sv
// Round-robin arbiter: grants the first requester after the last accepted one.
// last_grant only moves when the granted request is actually taken (advance).
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] last_grant_d;
    logic [N-1:0]  upper_mask;
    logic [N-1:0]  upper_req;
    logic [N-1:0]  grant_upper;
    logic [N-1:0]  grant_any;

    // Prefer the lowest requester above last_grant, else wrap to the lowest overall.
    always_comb begin
        upper_mask  = '0;
        grant_upper = '0;
        grant_any   = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (IW'(i) > last_grant_q);
        end
        upper_req = req & upper_mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                grant_upper    = '0;
                grant_upper[i] = 1'b1;
            end
            if (req[i]) begin
                grant_any    = '0;
                grant_any[i] = 1'b1;
            end
        end
        grant = (|upper_req) ? grant_upper : grant_any;
    end

    // Remember the winner only when its request was accepted.
    always_comb begin
        last_grant_d = last_grant_q;
        for (int i = 0; i < N; i++) begin
            if (advance && grant[i]) begin
                last_grant_d = IW'(i);
            end
        end
    end

    // last_grant state; resets to N-1 so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= IW'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Shares one FP add/sub/compare unit among N_REQ requesters. Requests are
// arbitrated round-robin, issued from registers, tracked through a tag
// pipeline matching the unit latency and returned in per-requester
// single-entry response registers.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. req_ready is combinational from req_valid; each requester may hold at
// most one operation in flight, so a response register can never be overrun.
module fpu_addsub_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int LATENCY = 1,
    localparam int TAG_W  = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    input  logic [N_REQ-1:0][1:0]  req_op,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [N_REQ-1:0][31:0] rsp_y,
    output logic [N_REQ-1:0]       rsp_a_hi_b,
    output logic [N_REQ-1:0]       rsp_a_equal_b,
    output logic [31:0]            fu_a,
    output logic [31:0]            fu_b,
    output logic                   fu_sub,
    output logic                   fu_comp,
    input  logic [31:0]            fu_y,
    input  logic                   fu_a_hi_b,
    input  logic                   fu_a_equal_b
);

    // Stage 0 is the issue register itself; stage LATENCY lines up with fu_y.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             is_cmp;
    } pipe_t;

    logic [N_REQ-1:0]       busy_q, busy_d;
    logic [N_REQ-1:0]       eligible;
    logic [N_REQ-1:0]       grant;
    logic                   accept;
    logic [TAG_W-1:0]       accept_tag;
    logic [31:0]            sel_a, sel_b;
    logic [1:0]             sel_op;
    fu_mode_t               sel_mode;

    logic [31:0]            fu_a_q, fu_a_d;
    logic [31:0]            fu_b_q, fu_b_d;
    logic                   fu_sub_q, fu_sub_d;
    logic                   fu_comp_q, fu_comp_d;

    pipe_t                  pipe_q [LATENCY+1];
    pipe_t                  pipe_d [LATENCY+1];
    pipe_t                  head;

    logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0][31:0] rsp_y_q, rsp_y_d;
    logic [N_REQ-1:0]       rsp_hi_q, rsp_hi_d;
    logic [N_REQ-1:0]       rsp_eq_q, rsp_eq_d;

    assign eligible = req_valid & ~busy_q;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (eligible),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = reset ? '0 : grant;
    assign accept    = |req_ready;
    assign head      = pipe_q[LATENCY];

    assign fu_a          = fu_a_q;
    assign fu_b          = fu_b_q;
    assign fu_sub        = fu_sub_q;
    assign fu_comp       = fu_comp_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_y         = rsp_y_q;
    assign rsp_a_hi_b    = rsp_hi_q;
    assign rsp_a_equal_b = rsp_eq_q;

    // Mux the granted requester's operands and tag (grant is one-hot or zero).
    always_comb begin
        accept_tag = '0;
        sel_a      = '0;
        sel_b      = '0;
        sel_op     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                accept_tag = TAG_W'(i);
                sel_a      = req_a[i];
                sel_b      = req_b[i];
                sel_op     = req_op[i];
            end
        end
        sel_mode = decode_op(sel_op);
    end

    // Issue register: loads on accept, otherwise holds operands and mode.
    always_comb begin
        fu_a_d    = fu_a_q;
        fu_b_d    = fu_b_q;
        fu_sub_d  = fu_sub_q;
        fu_comp_d = fu_comp_q;
        if (accept) begin
            fu_a_d    = sel_a;
            fu_b_d    = sel_b;
            fu_sub_d  = sel_mode.sub;
            fu_comp_d = sel_mode.comp;
        end
    end

    // Tag pipeline: stage 0 valid for one cycle per issue, then shift toward the head.
    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = accept;
        if (accept) begin
            pipe_d[0].tag    = accept_tag;
            pipe_d[0].is_cmp = sel_mode.comp;
        end
        for (int s = 1; s <= LATENCY; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    // Busy: set on accept, cleared when the response is consumed.
    always_comb begin
        busy_d = (busy_q & ~(rsp_valid_q & rsp_ready)) | req_ready;
    end

    // Response registers: clear on handshake, capture unit outputs at the pipeline head.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_eq_d    = rsp_eq_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
            if (head.valid && (head.tag == TAG_W'(i))) begin
                rsp_valid_d[i] = 1'b1;
                rsp_y_d[i]     = head.is_cmp ? 32'h0 : fu_y;
                rsp_hi_d[i]    = fu_a_hi_b;
                rsp_eq_d[i]    = fu_a_equal_b;
            end
        end
    end

    // State registers; reset drops in-flight work and zeroes all data.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q      <= '0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            fu_sub_q    <= 1'b0;
            fu_comp_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            rsp_hi_q    <= '0;
            rsp_eq_q    <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            fu_sub_q    <= fu_sub_d;
            fu_comp_q   <= fu_comp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_eq_q    <= rsp_eq_d;
            for (int s = 0; s <= LATENCY; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter with N_REQ=2, LATENCY=1. A registered stand-in
// unit computes exact results for small integer-valued floats (0.0 .. 8.0).
module tb_fpu_addsub_arbiter;
    import fpu_pkg::*;

    logic              clock;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_a, req_b;
    logic [1:0][1:0]   req_op;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_y;
    logic [1:0]        rsp_a_hi_b, rsp_a_equal_b;
    logic [31:0]       fu_a, fu_b, fu_y;
    logic              fu_sub, fu_comp, fu_a_hi_b, fu_a_equal_b;

    logic              tb_valid [2];
    logic [31:0]       tb_a [2];
    logic [31:0]       tb_b [2];
    logic [1:0]        tb_op [2];

    assign req_valid = {tb_valid[1], tb_valid[0]};
    assign req_a     = {tb_a[1], tb_a[0]};
    assign req_b     = {tb_b[1], tb_b[0]};
    assign req_op    = {tb_op[1], tb_op[0]};

    logic [33:0] exp_q [2][$];
    int          grant_log [$];
    int          rsp_cnt [2];
    int          checks;
    int          errors;

    logic [31:0] fvals [9] = '{32'h00000000, 32'h3F800000, 32'h40000000,
                               32'h40400000, 32'h40800000, 32'h40A00000,
                               32'h40C00000, 32'h40E00000, 32'h41000000};

    fpu_addsub_arbiter #(.N_REQ(2), .LATENCY(1)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_y         (rsp_y),
        .rsp_a_hi_b    (rsp_a_hi_b),
        .rsp_a_equal_b (rsp_a_equal_b),
        .fu_a          (fu_a),
        .fu_b          (fu_b),
        .fu_sub        (fu_sub),
        .fu_comp       (fu_comp),
        .fu_y          (fu_y),
        .fu_a_hi_b     (fu_a_hi_b),
        .fu_a_equal_b  (fu_a_equal_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stand-in FP unit (one register stage) ----------------
    function automatic int fidx(input logic [31:0] v);
        for (int i = 0; i < 9; i++) if (fvals[i] == v) return i;
        return -1;
    endfunction

    function automatic logic [33:0] unit_model(input logic [31:0] a, b, input logic sub, comp);
        int ia, ib;
        logic [31:0] y;
        ia = fidx(a);
        ib = fidx(b);
        if (ia < 0 || ib < 0) return {FP_QNAN, 2'b00};
        if (comp)                 y = a;   // arbitrary non-zero; arbiter must zero it
        else if (sub)             y = (ia >= ib) ? fvals[ia - ib] : FP_QNAN;
        else                      y = (ia + ib <= 8) ? fvals[ia + ib] : FP_PINF;
        return {y, (ia > ib), (ia == ib)};
    endfunction

    always @(posedge clock) begin
        {fu_y, fu_a_hi_b, fu_a_equal_b} <= unit_model(fu_a, fu_b, fu_sub, fu_comp);
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor / grant logger ----------------
    task automatic monitor_loop();
        logic [33:0] e;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                for (int r = 0; r < 2; r++) begin
                    if (rsp_valid[r] && rsp_ready[r]) begin
                        checks++;
                        rsp_cnt[r]++;
                        if (exp_q[r].size() == 0) begin
                            errors++;
                            $display("FAIL rsp_unexpected r%0d: got y=%h, required no response", r, rsp_y[r]);
                        end else begin
                            e = exp_q[r].pop_front();
                            if ({rsp_y[r], rsp_a_hi_b[r], rsp_a_equal_b[r]} !== e) begin
                                errors++;
                                $display("FAIL rsp r%0d: got y=%h hi=%b eq=%b, required y=%h hi=%b eq=%b",
                                         r, rsp_y[r], rsp_a_hi_b[r], rsp_a_equal_b[r], e[33:2], e[1], e[0]);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic grant_logger();
        forever begin
            @(posedge clock);
            if (!reset) for (int r = 0; r < 2; r++) if (req_ready[r]) grant_log.push_back(r);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present a request and return on the edge that accepts it (valid left high).
    task automatic drive(input int r, input logic [31:0] a, b, input logic [1:0] op, input logic [33:0] e);
        bit ok;
        ok = 0;
        @(negedge clock);
        tb_valid[r] = 1'b1;
        tb_a[r]     = a;
        tb_b[r]     = b;
        tb_op[r]    = op;
        for (int c = 0; c < 200 && !ok; c++) begin
            #1;
            if (req_ready[r]) begin
                @(posedge clock);
                exp_q[r].push_back(e);
                ok = 1;
            end else begin
                @(negedge clock);
            end
        end
        if (!ok) check($sformatf("accept_timeout_r%0d", r), 64'(ok), 64'd1);
    endtask

    task automatic burst(input int r, input int n);
        int ia, ib;
        for (int k = 0; k < n; k++) begin
            ia = $urandom_range(0, 4);
            ib = $urandom_range(0, 4);
            drive(r, fvals[ia], fvals[ib], FP_ADD, {fvals[ia + ib], 1'(ia > ib), 1'(ia == ib)});
        end
        @(negedge clock);
        tb_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            #3;
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
        end
        check("drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        grant_log.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          r;
        logic [31:0] a, b;
        logic [1:0]  op;
        logic [31:0] y;
        logic        hi, eq;
    } vec_t;

    vec_t vecs [8];
    int   cnt_before;

    initial begin
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 1'b0, 1'b0};
        vecs[1] = '{1, 32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, 1'b1, 1'b0};
        vecs[2] = '{0, 32'h40000000, 32'h3F800000, 2'b10, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{1, 32'h3F800000, 32'h3F800000, 2'b10, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{1, 32'h40800000, 32'h40800000, 2'b00, 32'h41000000, 1'b0, 1'b1};
        vecs[5] = '{0, 32'h40000000, 32'h40A00000, 2'b01, FP_QNAN,      1'b0, 1'b0};
        vecs[6] = '{0, 32'h3F800000, 32'h40400000, 2'b10, 32'h00000000, 1'b0, 1'b0};
        vecs[7] = '{1, 32'h40000000, 32'h40400000, 2'b11, 32'h40A00000, 1'b0, 1'b0};

        checks = 0;
        errors = 0;
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
        for (int r = 0; r < 2; r++) begin
            tb_valid[r] = 1'b0;
            tb_a[r]     = '0;
            tb_b[r]     = '0;
            tb_op[r]    = '0;
        end
        rsp_ready = 2'b11;
        reset     = 1'b1;

        fork
            monitor_loop();
            grant_logger();
        join_none

        // Reset values, with both requesters asserting valid during reset.
        @(negedge clock);
        tb_valid[0] = 1'b1;
        tb_valid[1] = 1'b1;
        @(negedge clock);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_fu", 64'({fu_a, fu_sub, fu_comp}), 64'd0);
        check("reset_rsp_y", 64'(rsp_y), 64'd0);
        tb_valid[0] = 1'b0;
        tb_valid[1] = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Latency: 1.0 + 2.0 on requester 0, response exactly two edges after accept.
        @(negedge clock);
        tb_valid[0] = 1'b1;
        tb_a[0]     = 32'h3F800000;
        tb_b[0]     = 32'h40000000;
        tb_op[0]    = FP_ADD;
        #1;
        check("lat_first_grant", 64'(req_ready), 64'b01);
        @(posedge clock);
        exp_q[0].push_back({32'h40400000, 1'b0, 1'b0});
        @(negedge clock);
        tb_valid[0] = 1'b0;
        check("lat_t1_fu", 64'({fu_a, fu_b}), {32'h3F800000, 32'h40000000});
        check("lat_t1_mode", 64'({fu_sub, fu_comp}), 64'b00);
        check("lat_t1_rsp", 64'(rsp_valid[0]), 64'd0);
        @(negedge clock);
        check("lat_t2_rsp", 64'(rsp_valid[0]), 64'd0);
        check("lat_t2_fu_hold", 64'(fu_a), 64'h3F800000);
        @(negedge clock);
        check("lat_t3_rsp", 64'(rsp_valid[0]), 64'd1);
        wait_idle();

        // Table-driven single operations.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, {vecs[i].y, vecs[i].hi, vecs[i].eq});
            @(negedge clock);
            tb_valid[vecs[i].r] = 1'b0;
            wait_idle();
        end

        // Contention: both requesters valid right after reset, grants alternate.
        pulse_reset();
        fork
            burst(0, 3);
            burst(1, 3);
        join
        wait_idle();
        check("cont_grant_count", 64'(grant_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            check($sformatf("cont_grant_%0d", k), 64'(grant_log[k]), 64'(k % 2));
        end

        // Backpressure on requester 0 while requester 1 keeps being served.
        rsp_ready[0] = 1'b0;
        cnt_before   = rsp_cnt[1];
        drive(0, 32'h40000000, 32'h40000000, FP_ADD, {32'h40800000, 1'b0, 1'b1});
        @(negedge clock);
        tb_valid[0] = 1'b0;
        fork
            begin
                for (int c = 0; c < 10 && !rsp_valid[0]; c++) @(negedge clock);
                for (int c = 0; c < 5; c++) begin
                    tb_valid[0] = 1'b1;
                    tb_a[0]     = 32'h3F800000;
                    tb_b[0]     = 32'h3F800000;
                    tb_op[0]    = FP_SUB;
                    #1;
                    check($sformatf("bp_rsp_valid_%0d", c), 64'(rsp_valid[0]), 64'd1);
                    check($sformatf("bp_rsp_y_%0d", c), 64'(rsp_y[0]), 64'h40800000);
                    check($sformatf("bp_req_ready_%0d", c), 64'(req_ready[0]), 64'd0);
                    @(negedge clock);
                end
                tb_valid[0] = 1'b0;
            end
            burst(1, 2);
        join
        rsp_ready[0] = 1'b1;
        wait_idle();
        check("bp_r1_served", 64'(rsp_cnt[1] - cnt_before), 64'd2);

        // Reset one cycle after accept: no response, requester 0 wins first afterwards.
        drive(0, 32'h40C00000, 32'h3F800000, FP_SUB, {32'h40A00000, 1'b1, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        exp_q[0].delete();
        tb_valid[0] = 1'b1;
        tb_valid[1] = 1'b1;
        tb_a[0] = 32'h3F800000; tb_b[0] = 32'h3F800000; tb_op[0] = FP_ADD;
        tb_a[1] = 32'h40000000; tb_b[1] = 32'h40000000; tb_op[1] = FP_ADD;
        @(negedge clock);
        #1;
        check("rst_mid_req_ready", 64'(req_ready), 64'd0);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_fu_a", 64'(fu_a), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_first_grant", 64'(req_ready), 64'b01);
        @(posedge clock);
        exp_q[0].push_back({32'h40000000, 1'b0, 1'b1});
        @(negedge clock);
        tb_valid[0] = 1'b0;
        tb_valid[1] = 1'b0;
        check("rst_no_rsp_a", 64'(rsp_valid), 64'd0);
        @(negedge clock);
        check("rst_no_rsp_b", 64'(rsp_valid), 64'd0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
